// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait stall, redirect flush and
// load-use interlock, all decided combinationally in the cycle they occur.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [1:0]  EX_MEM_PCsrc,
  input  logic        mem_ready,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        ID_EX_write,
  output logic        EX_MEM_write,
  output logic        MEM_WB_write,
  output logic        IF_ID_reset,
  output logic        ID_EX_reset,
  output logic        EX_MEM_reset,
  output logic        MEM_WB_reset,
  output logic        mem_req,
  output logic        mem_error,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [7:0] TO_M1 = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       memstall, redirect, load_use;

  assign mem_req  = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign memstall = mem_req & ~mem_ready;
  assign redirect = ~memstall & (EX_MEM_PCsrc != 2'b00);
  // ID holds a bubble right after a flush, so its register fields are stale
  assign load_use = ~memstall & (EX_MEM_PCsrc == 2'b00) & (state_q != FLUSH) &
                    ID_EX_MemRead & (ID_EX_Rt != 5'd0) &
                    ((ID_EX_Rt == IF_ID_rs) | (ID_EX_Rt == IF_ID_rt));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN, MEM_WAIT, FLUSH: begin
        if (memstall)      state_d = MEM_WAIT;
        else if (redirect) state_d = FLUSH;
        else               state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_write  = 1'b1;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    IF_ID_reset  = 1'b0;
    ID_EX_reset  = 1'b0;
    EX_MEM_reset = 1'b0;
    MEM_WB_reset = 1'b0;
    if (reset) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      IF_ID_reset  = 1'b1;
      ID_EX_reset  = 1'b1;
      EX_MEM_reset = 1'b1;
      MEM_WB_reset = 1'b1;
    end else if (memstall) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      MEM_WB_reset = 1'b1;
    end else if (redirect) begin
      IF_ID_reset  = 1'b1;
      ID_EX_reset  = 1'b1;
      EX_MEM_reset = 1'b1;
    end else if (load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_reset  = 1'b1;
    end
  end

  // Wait counter holds at its top value so a long stall cannot wrap it back
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 8'd0;
      mem_error <= 1'b0;
    end else if (memstall) begin
      if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      if (wait_cnt >= TO_M1) mem_error <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if ((memstall | load_use) && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (redirect && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a negedge monitor
// pops and compares them against the controller.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] IF_ID_rs = '0, IF_ID_rt = '0, ID_EX_Rt = '0;
  logic ID_EX_MemRead = 1'b0, EX_MEM_MemRead = 1'b0, EX_MEM_MemWrite = 1'b0;
  logic [1:0] EX_MEM_PCsrc = '0;
  logic mem_ready = 1'b1;
  logic PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic IF_ID_reset, ID_EX_reset, EX_MEM_reset, MEM_WB_reset;
  logic mem_req, mem_error;
  logic [15:0] stall_count, flush_count;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_PCsrc(EX_MEM_PCsrc), .mem_ready(mem_ready),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
    .IF_ID_reset(IF_ID_reset), .ID_EX_reset(ID_EX_reset),
    .EX_MEM_reset(EX_MEM_reset), .MEM_WB_reset(MEM_WB_reset),
    .mem_req(mem_req), .mem_error(mem_error),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs, rt, ex_rt;
    logic       ex_mr, mm_r, mm_w, rdy;
    logic [1:0] pcsrc;
  } stim_t;

  typedef struct packed {
    logic [4:0]  wr;   // PC, IF_ID, ID_EX, EX_MEM, MEM_WB
    logic [3:0]  rst;  // IF_ID, ID_EX, EX_MEM, MEM_WB
    logic        mreq, merr;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference state: whether the previous cycle redirected, length of the
  // current memory-stall run, sticky error, event totals.
  bit m_after_flush;
  int m_stall_run, m_sc, m_fc;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_after_flush = 0; m_stall_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
  endfunction

  function automatic bit is_stall(input stim_t s);
    return (s.mm_r || s.mm_w) && !s.rdy;
  endfunction

  function automatic bit is_lu(input stim_t s);
    return !is_stall(s) && s.pcsrc == 0 && !m_after_flush && s.ex_mr &&
           s.ex_rt != 0 && (s.ex_rt == s.rs || s.ex_rt == s.rt);
  endfunction

  function automatic exp_t predict(input stim_t s, input bit in_rst);
    exp_t e;
    e.mreq = s.mm_r | s.mm_w;
    e.merr = m_err;
    e.sc   = 16'(m_sc);
    e.fc   = 16'(m_fc);
    if (in_rst)                    begin e.wr = 5'b00000; e.rst = 4'b1111; end
    else if (is_stall(s))          begin e.wr = 5'b00000; e.rst = 4'b0001; end
    else if (s.pcsrc != 0)         begin e.wr = 5'b11111; e.rst = 4'b1110; end
    else if (is_lu(s))             begin e.wr = 5'b00111; e.rst = 4'b0100; end
    else                           begin e.wr = 5'b11111; e.rst = 4'b0000; end
    return e;
  endfunction

  function automatic void advance(input stim_t s);
    bit st, lu, rd;
    st = is_stall(s);
    lu = is_lu(s);
    rd = !st && s.pcsrc != 0;
    m_stall_run = st ? m_stall_run + 1 : 0;
    if (m_stall_run >= TO) m_err = 1;
    if ((st || lu) && m_sc < 65535) m_sc++;
    if (rd && m_fc < 65535) m_fc++;
    m_after_flush = rd;
  endfunction

  task automatic step(input stim_t s, input bit hold_rst, input bit pulse);
    @(posedge clock); #1;
    IF_ID_rs = s.rs; IF_ID_rt = s.rt; ID_EX_Rt = s.ex_rt;
    ID_EX_MemRead = s.ex_mr; EX_MEM_MemRead = s.mm_r; EX_MEM_MemWrite = s.mm_w;
    EX_MEM_PCsrc = s.pcsrc; mem_ready = s.rdy;
    reset = hold_rst;
    if (pulse) begin #1; reset = 1'b1; end
    if (reset) model_clear();
    sb.push_back(predict(s, reset));
    if (pulse) begin @(negedge clock); #1; reset = 1'b0; end
    if (!reset) advance(s);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("writes", {27'd0, PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write}, {27'd0, e.wr});
      chk("resets", {28'd0, IF_ID_reset, ID_EX_reset, EX_MEM_reset, MEM_WB_reset}, {28'd0, e.rst});
      chk("mem_req", {31'd0, mem_req}, {31'd0, e.mreq});
      chk("mem_error", {31'd0, mem_error}, {31'd0, e.merr});
      chk("stall_count", {16'd0, stall_count}, {16'd0, e.sc});
      chk("flush_count", {16'd0, flush_count}, {16'd0, e.fc});
    end
  end

  initial begin
    stim_t idle, s;
    idle = '{rs: 5'd0, rt: 5'd0, ex_rt: 5'd0, ex_mr: 1'b0, mm_r: 1'b0,
             mm_w: 1'b0, rdy: 1'b1, pcsrc: 2'b00};
    model_clear();

    // held reset, with a memory access present so mem_req must still follow
    s = idle; s.mm_w = 1'b1; s.rdy = 1'b0;
    repeat (2) step(s, 1, 0);
    step(idle, 1, 0);
    step(idle, 0, 0);

    // load-use on rs, then Rt=0 non-hazard
    s = idle; s.ex_mr = 1; s.ex_rt = 5'd5; s.rs = 5'd5;
    step(s, 0, 0);
    step(idle, 0, 0);
    s = idle; s.ex_mr = 1; s.ex_rt = 5'd0; s.rt = 5'd0;
    step(s, 0, 0);

    // memory wait of three cycles
    s = idle; s.mm_r = 1; s.rdy = 0;
    repeat (3) step(s, 0, 0);
    s.rdy = 1;
    step(s, 0, 0);
    step(idle, 0, 0);

    // redirect over a load-use, load-use suppressed in the FLUSH cycle
    s = idle; s.ex_mr = 1; s.ex_rt = 5'd7; s.rt = 5'd7; s.pcsrc = 2'b01;
    step(s, 0, 0);
    s.pcsrc = 2'b00;
    step(s, 0, 0);
    step(s, 0, 0);
    step(idle, 0, 0);

    // redirect held during a memory stall, acted on when ready rises
    s = idle; s.mm_w = 1; s.rdy = 0; s.pcsrc = 2'b10;
    repeat (2) step(s, 0, 0);
    s.rdy = 1;
    step(s, 0, 0);
    step(idle, 0, 0);

    // timeout: six wait cycles with a limit of four
    s = idle; s.mm_r = 1; s.rdy = 0;
    repeat (6) step(s, 0, 0);
    s.rdy = 1;
    step(s, 0, 0);
    step(idle, 0, 0);

    // reset pulse between edges during a wait
    s = idle; s.mm_r = 1; s.rdy = 0;
    repeat (2) step(s, 0, 0);
    step(s, 0, 1);
    step(idle, 0, 0);
    step(idle, 0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.ex_rt = 5'($urandom_range(0, 3));
      s.ex_mr = 1'($urandom_range(0, 1));
      s.mm_r  = ($urandom_range(0, 3) == 0);
      s.mm_w  = ($urandom_range(0, 5) == 0);
      s.rdy   = ($urandom_range(0, 3) != 0);
      s.pcsrc = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(s, 0, (i % 150) == 149);
    end

    step(idle, 0, 0);
    @(negedge clock); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, meaning the maximum number of consecutive memory-wait cycles before mem_error is raised (legal range 1..255).
REQ-002 clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 IF_ID_rs, IF_ID_rt  in  5 each  source register addresses of the instruction in ID.
REQ-005 ID_EX_MemRead  in  1, ID_EX_Rt  in  5  load flag and destination register of the instruction in EX.
REQ-006 EX_MEM_MemRead, EX_MEM_MemWrite  in  1 each  memory access flags of the instruction in MEM.
REQ-007 EX_MEM_PCsrc  in  2  redirect select of the instruction in MEM; nonzero means taken branch or jump.
REQ-008 mem_ready  in  1  data memory completion handshake.
REQ-009 PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write  out  1 each  hold-enable for the PC and each pipeline register (1 = load).
REQ-010 IF_ID_reset, ID_EX_reset, EX_MEM_reset, MEM_WB_reset  out  1 each  synchronous bubble/clear request to each pipeline register.
REQ-011 mem_req  out  1  data memory access request.
REQ-012 mem_error  out  1  sticky memory timeout flag.
REQ-013 stall_count, flush_count  out  16 each  saturating event counters.

Function
REQ-014 FSM states SHALL be RUN, MEM_WAIT and FLUSH, encoded in 2 bits; the unused encoding SHALL return to RUN on the next clock.
REQ-015 mem_req SHALL equal EX_MEM_MemRead | EX_MEM_MemWrite in every state.
REQ-016 A memory stall (memstall = mem_req & ~mem_ready) SHALL have the highest priority.
  - All five *_write SHALL be 0.
  - MEM_WB_reset SHALL be 1.
  - All other *_reset SHALL be 0.
  - The next state SHALL be MEM_WAIT.
REQ-017 In MEM_WAIT, mem_ready=1 SHALL end the stall combinationally in that same cycle, and the next state SHALL be chosen by the RUN rules.
REQ-018 A wait counter (8 bits) SHALL increment each cycle memstall=1 and clear when memstall=0.
  - When it reaches MEM_TIMEOUT, mem_error SHALL set and stay set until reset.
  - The stall SHALL continue after mem_error sets.
REQ-019 Redirect has second priority, when memstall=0 and EX_MEM_PCsrc!=0.
  - IF_ID_reset, ID_EX_reset and EX_MEM_reset SHALL be 1.
  - All *_write SHALL be 1.
  - The next state SHALL be FLUSH.
  - flush_count SHALL increment.
REQ-020 In FLUSH, load-use detection SHALL be suppressed for one cycle, because ID holds a bubble; the next state SHALL be RUN unless another stall or redirect applies.
REQ-021 Load-use has third priority: memstall=0, PCsrc=0, state != FLUSH, ID_EX_MemRead=1, ID_EX_Rt!=0 and (ID_EX_Rt==IF_ID_rs or ID_EX_Rt==IF_ID_rt).
  - PC_write and IF_ID_write SHALL be 0.
  - ID_EX_reset SHALL be 1.
  - All other *_write SHALL be 1 and all other *_reset SHALL be 0.
REQ-022 When no condition holds, all *_write SHALL be 1 and all *_reset SHALL be 0.
REQ-023 stall_count SHALL increment on every cycle with memstall or load-use active.
REQ-024 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-025 All control outputs SHALL be combinational from the current inputs and state; the zero-latency decision SHALL apply in the same cycle.
REQ-026 A simultaneous redirect and memstall SHALL be served as memstall first; the redirect SHALL be acted on in the cycle mem_ready rises, provided PCsrc is still held.

Reset
REQ-027 While reset=1, regardless of clock:
  - state SHALL be RUN.
  - The wait counter, stall_count, flush_count and mem_error SHALL be 0.
  - All *_write SHALL be 0.
  - All *_reset SHALL be 1.
  - mem_req SHALL still follow REQ-015.
REQ-028 Reset asserted during MEM_WAIT or FLUSH SHALL abort the operation immediately; after deassertion the first clock SHALL evaluate from RUN.

Verification
REQ-029 Load-use: ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_rs=5 -> PC_write=0, IF_ID_write=0, ID_EX_reset=1 for exactly one cycle; stall_count=1.
REQ-030 Rt=0 hazard: ID_EX_Rt=0, IF_ID_rt=0, ID_EX_MemRead=1 -> no stall; all writes 1.
REQ-031 Memory wait: EX_MEM_MemRead=1, mem_ready low 3 cycles then high -> all writes 0 and MEM_WB_reset=1 for 3 cycles, normal on the 4th; stall_count=3.
REQ-032 Timeout: MEM_TIMEOUT=4, mem_ready held low 6 cycles -> mem_error=1 from the cycle after the count reaches 4, and still 1 after mem_ready rises.
REQ-033 Redirect: EX_MEM_PCsrc=2'b01 for 1 cycle while a load-use condition is present -> three flush resets=1, PC_write=1, load-use ignored in that cycle and the next FLUSH cycle; flush_count=1.
REQ-034 Async reset mid-MEM_WAIT: pulse reset between clock edges -> outputs go to REQ-027 values immediately; counters 0 and state RUN after release.
